// File: rtl/memory.sv
// Single-port word-addressed RAM for the KLP32 core: synchronous write, asynchronous read.
// Every word clears immediately when rst_n falls, so the array is built from resettable registers.
module memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (write_enable) begin
            mem_reg[addr] <= write_data;
        end
    end

    // No bypass: a same-address write shows up only after the edge.
    always_comb begin
        read_data = '0;
        if (rst_n) begin
            read_data = mem_reg[addr];
        end
    end

endmodule

// File: tb/tb_memory.sv
// Randomized self-checking bench for memory: an array model checked every cycle,
// plus directed literal checks for write/readback, isolation, gating, async reset and boundaries.
module tb_memory;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          write_enable = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] read_data;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] ref_mem [DEPTH];

    memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (write_enable),
        .addr         (addr),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    always #5 clk = ~clk;

    // Reference model: a plain array, cleared on reset, written at edges.
    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (rst_n && write_enable) ref_mem[addr] = write_data;
    end

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return rst_n ? ref_mem[a] : '0;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: addr=%0d read_data=%h expected=%h at %0t", name, addr, got, exp, $time);
        end else begin
            $display("ok   %s: addr=%0d read_data=%h", name, addr, got);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        vectors++;
        if (read_data !== model_read(addr)) begin
            miscompares++;
            $display("FAIL cycle: addr=%0d we=%0b rst_n=%0b read_data=%h expected=%h at %0t",
                     addr, write_enable, rst_n, read_data, model_read(addr), $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        addr = 10'd5;
        #1 check("reset_state", read_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // Write then read back
        write_enable = 1'b1; addr = 10'd0; write_data = 32'hDEADBEEF;
        tick();
        write_enable = 1'b0;
        #1 check("write_readback", read_data, 32'hDEADBEEF);

        // Isolation between words
        write_enable = 1'b1; addr = 10'd2; write_data = 32'h12345678;
        tick();
        write_enable = 1'b0;
        #1 check("isolation_addr2", read_data, 32'h12345678);
        addr = 10'd0;
        #1 check("isolation_addr0", read_data, 32'hDEADBEEF);
        addr = 10'd3;
        #1 check("unwritten_addr3", read_data, 32'h0);

        // Write-enable gating
        write_enable = 1'b0; addr = 10'd0; write_data = 32'hFFFFFFFF;
        tick(); tick(); tick();
        check("we_gating", read_data, 32'hDEADBEEF);

        // Async reset mid-cycle, with a write attempted during reset
        #2 rst_n = 1'b0;
        write_enable = 1'b1; addr = 10'd0; write_data = 32'h00000001;
        #1 check("async_reset_addr0", read_data, 32'h0);
        addr = 10'd2;
        #1 check("async_reset_addr2", read_data, 32'h0);
        addr = 10'd0;
        tick();
        write_enable = 1'b0;
        rst_n = 1'b1;
        #1 check("no_write_in_reset", read_data, 32'h0);
        tick();

        // Boundary address
        write_enable = 1'b1; addr = 10'd1023; write_data = 32'hA5A5A5A5;
        tick();
        write_enable = 1'b0;
        #1 check("boundary_1023", read_data, 32'hA5A5A5A5);
        addr = 10'd0;
        #1 check("boundary_addr0", read_data, 32'h0);

        // Read during write: old value before the edge, new value after
        write_enable = 1'b1; addr = 10'd1023; write_data = 32'h0BADF00D;
        #1 check("rdw_before_edge", read_data, 32'hA5A5A5A5);
        tick();
        write_enable = 1'b0;
        #1 check("rdw_after_edge", read_data, 32'h0BADF00D);

        // Back-to-back writes, last wins
        write_enable = 1'b1; addr = 10'd7; write_data = 32'h11111111;
        tick();
        write_data = 32'h22222222;
        tick();
        write_enable = 1'b0;
        #1 check("last_write_wins", read_data, 32'h22222222);

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 3000; n++) begin
            write_enable = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) addr = AW'($urandom_range(0, 15));
            else addr = AW'($urandom_range(0, DEPTH - 1));
            write_data = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_async_reset", read_data, 32'h0);
                tick();
                rst_n = 1'b1;
            end else begin
                #1 check("rand_pre_edge", read_data, model_read(addr));
                tick();
            end
        end
        write_enable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
